diamond_ctrl: RTL and testbench
===============================

# diamond_ctrl

Downstream consumer of `diamond_gen`. Takes the free-running candidate diamond coordinates and latches one as the live diamond, rejecting off-screen candidates and the snake head's own cell. It detects when the snake head eats the diamond, pulses an eat event, keeps the score, and holds off a fixed respawn delay before placing the next diamond. It also produces the per-pixel diamond mask for the VGA colouriser.

## Interface
Parameters:
- `SIZE`, 10: diamond/cell edge in pixels.
- `X_MIN`, 60: smallest accepted diamond x (top-left).
- `X_MAX`, 600: largest accepted diamond x.
- `Y_MIN`, 60: smallest accepted diamond y.
- `Y_MAX`, 460: largest accepted diamond y.
- `RESPAWN_DELAY`, 16: `vga_clk` cycles spent in WAIT after an eat (must be ≥1).
- `SCORE_W`, 8: score width.

Ports:
- `vga_clk`  in  1: 31.5 MHz pixel clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `x_rand`  in  12: candidate x from `diamond_gen`, new value every cycle.
- `y_rand`  in  12: candidate y from `diamond_gen`, new value every cycle.
- `head_x`  in  12: snake head top-left x.
- `head_y`  in  12: snake head top-left y.
- `head_valid`  in  1: one-cycle strobe; the snake head moved to (`head_x`,`head_y`) this cycle.
- `pixel_column`  in  12: current VGA column, 0..639.
- `pixel_row`  in  12: current VGA row, 0..479.
- `diamond_x`  out  12: latched diamond x.
- `diamond_y`  out  12: latched diamond y.
- `diamond_active`  out  1: a diamond is on the map.
- `eat_pulse`  out  1: one-cycle pulse per diamond eaten.
- `score`  out  `SCORE_W`: diamonds eaten, saturating.
- `diamond_pixel`  out  1: the current pixel lies inside the live diamond.

## Operation
- FSM states: SPAWN, ACTIVE, WAIT. The reset state is SPAWN.
- Reset values: `diamond_x`=0, `diamond_y`=0, `diamond_active`=0, `eat_pulse`=0, `score`=0, `diamond_pixel`=0, delay counter=0.
- **SPAWN** samples (`x_rand`,`y_rand`) every cycle. A candidate is accepted when all of these hold:
  - X_MIN ≤ x ≤ X_MAX;
  - Y_MIN ≤ y ≤ Y_MAX;
  - (x,y) ≠ (`head_x`,`head_y`).
- On accept: load `diamond_x`/`diamond_y`, set `diamond_active`=1, go to ACTIVE. On reject: stay in SPAWN and retry next cycle. There is no retry limit.
- **ACTIVE**: a hit is `head_valid`=1 with `head_x`==`diamond_x` and `head_y`==`diamond_y` (exact 12-bit equality).
  - On a hit: `eat_pulse`=1 for one cycle, `score` += 1 (saturating at 2^SCORE_W−1), `diamond_active`=0, load counter with RESPAWN_DELAY−1, go to WAIT.
  - Otherwise: hold.
- **WAIT**: decrement the counter each cycle. When the counter is 0, go to SPAWN.
- Hits outside ACTIVE are ignored: no pulse and no score change.
- `diamond_x`/`diamond_y` keep their last value after an eat until the next accept.
- **Mask**: `diamond_pixel` = `diamond_active` AND `diamond_x` ≤ `pixel_column` ≤ `diamond_x`+SIZE−1 AND `diamond_y` ≤ `pixel_row` ≤ `diamond_y`+SIZE−1.
  - Sums are computed in 12 bits; no overflow is possible for the parameter ranges.
  - The mask is registered.
- All arithmetic and comparisons are unsigned, 12-bit.

## Timing
- Accept latency: the candidate presented in cycle N appears on `diamond_x`/`diamond_y`, with `diamond_active`=1, after edge N+1.
- Eat latency: a hit presented in cycle N asserts `eat_pulse` and the new `score` after edge N+1. `diamond_active` drops on the same edge.
- `eat_pulse` is high for exactly one cycle per eat. Back-to-back pulses cannot occur, because WAIT plus SPAWN take ≥2 cycles.
- WAIT lasts exactly RESPAWN_DELAY cycles. The earliest re-accept is RESPAWN_DELAY+1 cycles after the `eat_pulse` cycle.
- `diamond_pixel` lags `pixel_column`/`pixel_row` by 1 cycle. The colouriser compensates.
- Reset is synchronous and overrides everything in the same edge, including a simultaneous hit or accept. Reset mid-WAIT returns the FSM to SPAWN with `score`=0.
- `head_valid` held high for multiple cycles in ACTIVE counts as one eat. The FSM leaves ACTIVE on the first hit.

## Test plan
- **Reset**: assert `reset` for 2 cycles while `head_valid`=1 on a matching position. Required: all outputs 0 throughout, FSM in SPAWN after release.
- **Reject then accept**: drive (x,y) = (630,100), then (60,470), then (300,200). Required: the first two are rejected (`diamond_active` stays 0); `diamond_x`=300, `diamond_y`=200, `diamond_active`=1 one cycle after the third.
- **Head-cell reject**: with head at (300,200), present candidate (300,200), then (310,200). Required: (310,200) is latched.
- **Eat and respawn**: with the diamond at (300,200), pulse `head_valid` with head (300,200). Required:
  - `eat_pulse` high for 1 cycle, `score` 0→1, `diamond_active`=0;
  - no accept for 16 cycles, then a valid candidate is latched on the next SPAWN cycle.
- **Non-hit, ignored hit and saturation**:
  - head (290,200) with `head_valid`: no pulse;
  - hit during WAIT: ignored;
  - with SCORE_W=8, 256 eats leave `score`=255.
- **Mask**: with the diamond at (300,200), sweep pixels. Required: `diamond_pixel`=1 exactly for columns 300..309 × rows 200..209, one cycle late; 0 at 299/310 and 199/210; 0 everywhere when `diamond_active`=0.

Source files
------------

// File: rtl/diamond_ctrl.sv
// Diamond placement and eat controller: latches an accepted candidate, detects
// the snake head eating it, keeps the score and produces the registered pixel mask.
module diamond_ctrl #(
    parameter int SIZE          = 10,
    parameter int X_MIN         = 60,
    parameter int X_MAX         = 600,
    parameter int Y_MIN         = 60,
    parameter int Y_MAX         = 460,
    parameter int RESPAWN_DELAY = 16,
    parameter int SCORE_W       = 8
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic [11:0]        x_rand,
    input  logic [11:0]        y_rand,
    input  logic [11:0]        head_x,
    input  logic [11:0]        head_y,
    input  logic               head_valid,
    input  logic [11:0]        pixel_column,
    input  logic [11:0]        pixel_row,
    output logic [11:0]        diamond_x,
    output logic [11:0]        diamond_y,
    output logic               diamond_active,
    output logic               eat_pulse,
    output logic [SCORE_W-1:0] score,
    output logic               diamond_pixel
);

    localparam int CNT_W = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(RESPAWN_DELAY - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [11:0]        EDGE      = 12'(SIZE - 1);

    typedef enum logic [1:0] {SPAWN, ACTIVE, WAIT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [11:0]        x_reg, x_next;
    logic [11:0]        y_reg, y_next;
    logic               active_reg, active_next;
    logic               pulse_reg, pulse_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic               pixel_reg, pixel_next;

    logic accept;
    logic hit;

    assign accept = (x_rand >= 12'(X_MIN)) && (x_rand <= 12'(X_MAX)) &&
                    (y_rand >= 12'(Y_MIN)) && (y_rand <= 12'(Y_MAX)) &&
                    !((x_rand == head_x) && (y_rand == head_y));
    assign hit    = head_valid && (head_x == x_reg) && (head_y == y_reg);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        active_next = active_reg;
        pulse_next  = 1'b0;
        score_next  = score_reg;
        case (state_reg)
            SPAWN: begin
                if (accept) begin
                    x_next      = x_rand;
                    y_next      = y_rand;
                    active_next = 1'b1;
                    state_next  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (hit) begin
                    pulse_next  = 1'b1;
                    active_next = 1'b0;
                    cnt_next    = CNT_LOAD;
                    state_next  = WAIT;
                    if (score_reg != SCORE_MAX)
                        score_next = score_reg + 1'b1;
                end
            end
            WAIT: begin
                if (cnt_reg == '0)
                    state_next = SPAWN;
                else
                    cnt_next = cnt_reg - 1'b1;
            end
            default: state_next = SPAWN;
        endcase

        // Mask is built from the currently registered diamond, one cycle behind the pixel.
        pixel_next = active_reg &&
                     (pixel_column >= x_reg) && (pixel_column <= x_reg + EDGE) &&
                     (pixel_row >= y_reg) && (pixel_row <= y_reg + EDGE);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_reg  <= SPAWN;
            cnt_reg    <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            active_reg <= 1'b0;
            pulse_reg  <= 1'b0;
            score_reg  <= '0;
            pixel_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            active_reg <= active_next;
            pulse_reg  <= pulse_next;
            score_reg  <= score_next;
            pixel_reg  <= pixel_next;
        end
    end

    assign diamond_x      = x_reg;
    assign diamond_y      = y_reg;
    assign diamond_active = active_reg;
    assign eat_pulse      = pulse_reg;
    assign score          = score_reg;
    assign diamond_pixel  = pixel_reg;

endmodule

// File: tb/tb_diamond_ctrl.sv
// Directed bench for diamond_ctrl: a vector table for reset/accept/mask/eat,
// then hand-written sequences for respawn timing, saturation and reset mid-WAIT.
module tb_diamond_ctrl;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [11:0] x_rand, y_rand, head_x, head_y, pixel_column, pixel_row;
    logic        head_valid;
    logic [11:0] diamond_x, diamond_y;
    logic        diamond_active, eat_pulse, diamond_pixel;
    logic [7:0]  score;

    int checks = 0;
    int errors = 0;

    diamond_ctrl dut (
        .vga_clk        (vga_clk),
        .reset          (reset),
        .x_rand         (x_rand),
        .y_rand         (y_rand),
        .head_x         (head_x),
        .head_y         (head_y),
        .head_valid     (head_valid),
        .pixel_column   (pixel_column),
        .pixel_row      (pixel_row),
        .diamond_x      (diamond_x),
        .diamond_y      (diamond_y),
        .diamond_active (diamond_active),
        .eat_pulse      (eat_pulse),
        .score          (score),
        .diamond_pixel  (diamond_pixel)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic        rst;
        logic [11:0] xr, yr, hx, hy;
        logic        hv;
        logic [11:0] col, row;
        logic        e_act;
        logic [11:0] e_x, e_y;
        logic        e_pulse;
        logic [7:0]  e_score;
        logic        e_pix;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic rst, input int xr, input int yr, input int hx,
                                input int hy, input logic hv, input int col, input int row,
                                input logic e_act, input int e_x, input int e_y,
                                input logic e_pulse, input int e_score, input logic e_pix);
        vec_t v;
        v.rst = rst; v.xr = 12'(xr); v.yr = 12'(yr); v.hx = 12'(hx); v.hy = 12'(hy);
        v.hv = hv; v.col = 12'(col); v.row = 12'(row);
        v.e_act = e_act; v.e_x = 12'(e_x); v.e_y = 12'(e_y);
        v.e_pulse = e_pulse; v.e_score = 8'(e_score); v.e_pix = e_pix;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic apply(input logic rst, input int xr, input int yr, input int hx, input int hy,
                         input logic hv, input int col, input int row);
        reset = rst; x_rand = 12'(xr); y_rand = 12'(yr); head_x = 12'(hx); head_y = 12'(hy);
        head_valid = hv; pixel_column = 12'(col); pixel_row = 12'(row);
        @(posedge vga_clk);
        #1;
    endtask

    task automatic eat_at(input int x, input int y, input int idx, input int exp_score);
        apply(0, 0, 0, x, y, 1, 0, 0);
        chk("eat_pulse", idx, 32'(eat_pulse), 1);
        chk("eat_score", idx, 32'(score), 32'(exp_score));
        $display("eat %0d at (%0d,%0d): pulse=%0d score=%0d", idx, x, y, eat_pulse, score);
    endtask

    int exp_score;

    initial begin
        reset = 1'b1; x_rand = '0; y_rand = '0; head_x = '0; head_y = '0;
        head_valid = 1'b0; pixel_column = '0; pixel_row = '0;

        //            rst  xr   yr   hx   hy  hv  col  row | act  x    y  pul sc pix
        vecs[0]  = mk(1, 300, 200, 300, 200, 1, 305, 205,   0,   0,   0, 0, 0, 0);
        vecs[1]  = mk(1, 300, 200, 300, 200, 1, 305, 205,   0,   0,   0, 0, 0, 0);
        vecs[2]  = mk(0, 630, 100,   0,   0, 0,   0,   0,   0,   0,   0, 0, 0, 0);
        vecs[3]  = mk(0,  60, 470,   0,   0, 0,   0,   0,   0,   0,   0, 0, 0, 0);
        vecs[4]  = mk(0,  59, 200,   0,   0, 0,   0,   0,   0,   0,   0, 0, 0, 0);
        vecs[5]  = mk(0, 601, 200,   0,   0, 0,   0,   0,   0,   0,   0, 0, 0, 0);
        vecs[6]  = mk(0, 300, 200,   0,   0, 0, 305, 205,   1, 300, 200, 0, 0, 0);
        vecs[7]  = mk(0,   0,   0, 290, 200, 1, 300, 200,   1, 300, 200, 0, 0, 1);
        vecs[8]  = mk(0,   0,   0,   0,   0, 0, 309, 209,   1, 300, 200, 0, 0, 1);
        vecs[9]  = mk(0,   0,   0,   0,   0, 0, 310, 205,   1, 300, 200, 0, 0, 0);
        vecs[10] = mk(0,   0,   0,   0,   0, 0, 299, 205,   1, 300, 200, 0, 0, 0);
        vecs[11] = mk(0,   0,   0,   0,   0, 0, 305, 199,   1, 300, 200, 0, 0, 0);
        vecs[12] = mk(0,   0,   0,   0,   0, 0, 305, 210,   1, 300, 200, 0, 0, 0);
        vecs[13] = mk(0,   0,   0, 300, 200, 1, 305, 205,   0, 300, 200, 1, 1, 1);
        vecs[14] = mk(0,   0,   0, 300, 200, 1, 305, 205,   0, 300, 200, 0, 1, 0);
        vecs[15] = mk(0, 310, 200, 300, 200, 1, 300, 200,   0, 300, 200, 0, 1, 0);

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].rst, int'(vecs[i].xr), int'(vecs[i].yr), int'(vecs[i].hx),
                  int'(vecs[i].hy), vecs[i].hv, int'(vecs[i].col), int'(vecs[i].row));
            chk("active", i, 32'(diamond_active), 32'(vecs[i].e_act));
            chk("dx",     i, 32'(diamond_x),      32'(vecs[i].e_x));
            chk("dy",     i, 32'(diamond_y),      32'(vecs[i].e_y));
            chk("pulse",  i, 32'(eat_pulse),      32'(vecs[i].e_pulse));
            chk("score",  i, 32'(score),          32'(vecs[i].e_score));
            chk("pixel",  i, 32'(diamond_pixel),  32'(vecs[i].e_pix));
            $display("vec %0d: act=%0d x=%0d y=%0d pulse=%0d score=%0d pix=%0d",
                     i, diamond_active, diamond_x, diamond_y, eat_pulse, score, diamond_pixel);
        end

        // Vectors 14 and 15 were WAIT cycles 1-2; 14 more complete the 16-cycle hold-off.
        for (int i = 0; i < 14; i++) begin
            apply(0, 310, 200, 300, 200, 0, 0, 0);
            chk("wait1_active", i, 32'(diamond_active), 0);
        end
        $display("first respawn window: act=%0d", diamond_active);
        // First SPAWN cycle: candidate equals head cell, must be rejected.
        apply(0, 300, 200, 300, 200, 0, 0, 0);
        chk("headcell_reject", 0, 32'(diamond_active), 0);
        apply(0, 310, 200, 300, 200, 0, 0, 0);
        chk("accept2_active", 0, 32'(diamond_active), 1);
        chk("accept2_x", 0, 32'(diamond_x), 310);
        chk("accept2_y", 0, 32'(diamond_y), 200);
        $display("head-cell reject then accept: x=%0d y=%0d act=%0d", diamond_x, diamond_y, diamond_active);

        // Second eat: exact WAIT length, then immediate accept on the first SPAWN cycle.
        eat_at(310, 200, 2, 2);
        for (int i = 0; i < 16; i++) begin
            apply(0, 60, 60, 0, 0, 0, 0, 0);
            chk("wait2_active", i, 32'(diamond_active), 0);
            chk("wait2_pulse", i, 32'(eat_pulse), 0);
        end
        apply(0, 60, 60, 0, 0, 0, 0, 0);
        chk("respawn_active", 0, 32'(diamond_active), 1);
        chk("respawn_x", 0, 32'(diamond_x), 60);
        $display("respawn at boundary: x=%0d y=%0d act=%0d", diamond_x, diamond_y, diamond_active);

        // Saturation: keep eating well past 255.
        exp_score = 2;
        for (int n = 0; n < 258; n++) begin
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
            eat_at(60, 60, n + 3, exp_score);
            for (int i = 0; i < 16; i++) apply(0, 0, 0, 0, 0, 0, 0, 0);
            apply(0, 60, 60, 0, 0, 0, 0, 0);
        end
        chk("sat_score", 0, 32'(score), 255);
        chk("sat_active", 0, 32'(diamond_active), 1);

        // Reset in the middle of WAIT.
        eat_at(60, 60, 999, 255);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 60, 60, 0, 0, 0, 0, 0);
        chk("midwait_rst_score", 0, 32'(score), 0);
        chk("midwait_rst_active", 0, 32'(diamond_active), 0);
        chk("midwait_rst_x", 0, 32'(diamond_x), 0);
        apply(0, 60, 60, 0, 0, 0, 0, 0);
        chk("post_rst_accept", 0, 32'(diamond_active), 1);
        $display("reset mid-WAIT: score=%0d act=%0d", score, diamond_active);
        eat_at(60, 60, 1000, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
